// File: rtl/sin_meas_pkg.sv
// sin_meas_pkg: shared types, default widths and threshold helpers for the
// sine-stream measurement block (sin_meas) and its crossing detector (sin_xdet).
package sin_meas_pkg;

  localparam int unsigned DEF_DW       = 8;
  localparam int unsigned DEF_HYST     = 8;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_AVG_LOG2 = 2;
  localparam int unsigned DEF_TIMEOUT  = 65535;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  // Mid-scale code of an offset-binary sample of width dw.
  function automatic int unsigned mid_f(input int unsigned dw);
    return 32'(1) << (dw - 1);
  endfunction

  // Lower hysteresis threshold (arming level).
  function automatic int unsigned lo_f(input int unsigned dw, input int unsigned hyst);
    return mid_f(dw) - hyst;
  endfunction

  // Upper hysteresis threshold (crossing level).
  function automatic int unsigned hi_f(input int unsigned dw, input int unsigned hyst);
    return mid_f(dw) + hyst;
  endfunction

endpackage

// File: rtl/sin_meas_xdet.sv
// sin_xdet: converts the incoming sample to offset-binary and detects rising
// mid-scale crossings with hysteresis.
// Ports:
//   sclk, rst    clock, synchronous active-high reset
//   i_data       raw sample (two's complement when DATA_SIGNED=1)
//   i_valid      sample valid; state only advances on valid samples
//   o_u_c        offset-binary sample (combinational)
//   o_armed      armed flag (set by a sample <= LO)
//   o_xing_c     crossing pulse: valid sample, armed, and sample >= HI
module sin_xdet
  import sin_meas_pkg::*;
#(
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned DATA_SIGNED = 1,
  parameter int unsigned HYST        = DEF_HYST
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic [DW-1:0] o_u_c,
  output logic          o_armed,
  output logic          o_xing_c
);

  localparam logic [DW-1:0] MSB_MASK = DW'(mid_f(DW));
  localparam logic [DW-1:0] LO       = DW'(lo_f(DW, HYST));
  localparam logic [DW-1:0] HI       = DW'(hi_f(DW, HYST));

  logic r_armed;
  logic w_le_lo;
  logic w_ge_hi;

  // Flipping the MSB maps two's complement onto offset-binary.
  assign o_u_c    = (DATA_SIGNED != 0) ? (i_data ^ MSB_MASK) : i_data;
  assign w_le_lo  = (o_u_c <= LO);
  assign w_ge_hi  = (o_u_c >= HI);
  assign o_xing_c = i_valid & r_armed & w_ge_hi;
  assign o_armed  = r_armed;

  // Samples strictly between LO and HI leave the armed flag untouched.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (i_valid) begin
      if (w_le_lo)       r_armed <= 1'b1;
      else if (o_xing_c) r_armed <= 1'b0;
    end
  end

endmodule

// File: rtl/sin_meas.sv
// sin_meas: measures average period (in valid samples) and min/max/pk-pk
// amplitude of a sample stream over 2^AVG_LOG2 periods between rising
// mid-scale crossings; reports each result with a one-cycle meas_v strobe.
// Ports:
//   sclk, rst          clock, synchronous active-high reset
//   data_i, data_v     sample and valid strobe
//   period_o           averaged period (window sum >> AVG_LOG2)
//   max_o/min_o        window extremes, offset-binary
//   pkpk_o             max_o - min_o
//   meas_v             one-cycle pulse when the results update
//   lock_o             set on a completed window, cleared on loss of lock
//   timeout_o          sticky loss-of-lock flag, cleared on next window
module sin_meas
  import sin_meas_pkg::*;
#(
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned DATA_SIGNED = 1,
  parameter int unsigned HYST        = DEF_HYST,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned AVG_LOG2    = DEF_AVG_LOG2,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [DW-1:0]    data_i,
  input  logic             data_v,
  output logic [CNT_W-1:0] period_o,
  output logic [DW-1:0]    max_o,
  output logic [DW-1:0]    min_o,
  output logic [DW-1:0]    pkpk_o,
  output logic             meas_v,
  output logic             lock_o,
  output logic             timeout_o
);

  localparam int unsigned SUM_W  = CNT_W + AVG_LOG2;
  localparam int unsigned PCNT_W = AVG_LOG2 + 1;
  localparam int unsigned NPER   = 32'(1) << AVG_LOG2;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  state_t             r_state;
  logic [CNT_W-1:0]   r_scnt;
  logic [SUM_W-1:0]   r_sum;
  logic [PCNT_W-1:0]  r_pcnt;
  logic [DW-1:0]      r_min;
  logic [DW-1:0]      r_max;
  logic [CNT_W-1:0]   r_period;
  logic [DW-1:0]      r_max_o;
  logic [DW-1:0]      r_min_o;
  logic [DW-1:0]      r_pkpk;
  logic               r_meas_v;
  logic               r_lock;
  logic               r_timeout;

  logic [DW-1:0]      w_u;
  logic               w_armed;
  logic               w_xing;
  logic [CNT_W-1:0]   w_scnt_inc;
  logic [SUM_W-1:0]   w_sum_n;
  logic [PCNT_W-1:0]  w_pcnt_n;
  logic               w_close;
  logic               w_tmo;
  logic [DW-1:0]      w_min_n;
  logic [DW-1:0]      w_max_n;

  sin_xdet #(
    .DW          (DW),
    .DATA_SIGNED (DATA_SIGNED),
    .HYST        (HYST)
  ) u_xdet (
    .sclk     (sclk),
    .rst      (rst),
    .i_data   (data_i),
    .i_valid  (data_v),
    .o_u_c    (w_u),
    .o_armed  (w_armed),
    .o_xing_c (w_xing)
  );

  // Next-value helpers; the current sample is always folded into the trackers.
  assign w_scnt_inc = r_scnt + CNT_W'(1);
  assign w_sum_n    = r_sum + SUM_W'(w_scnt_inc);
  assign w_pcnt_n   = r_pcnt + PCNT_W'(1);
  assign w_close    = (w_pcnt_n == PCNT_W'(NPER));
  assign w_tmo      = (w_scnt_inc == CNT_W'(TIMEOUT));
  assign w_min_n    = (w_u < r_min) ? w_u : r_min;
  assign w_max_n    = (w_u > r_max) ? w_u : r_max;

  assign period_o  = r_period;
  assign max_o     = r_max_o;
  assign min_o     = r_min_o;
  assign pkpk_o    = r_pkpk;
  assign meas_v    = r_meas_v;
  assign lock_o    = r_lock;
  assign timeout_o = r_timeout;

  // Measurement FSM, counters, trackers and result registers.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_scnt    <= '0;
      r_sum     <= '0;
      r_pcnt    <= '0;
      r_min     <= ONES;
      r_max     <= '0;
      r_period  <= '0;
      r_max_o   <= '0;
      r_min_o   <= '0;
      r_pkpk    <= '0;
      r_meas_v  <= 1'b0;
      r_lock    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_meas_v <= 1'b0;
      if (data_v) begin
        case (r_state)
          IDLE: begin
            r_scnt <= '0;
            if (w_armed) r_state <= ARM;
          end
          ARM: begin
            if (w_xing) begin
              r_scnt  <= '0;
              r_sum   <= '0;
              r_pcnt  <= '0;
              r_min   <= ONES;
              r_max   <= '0;
              r_state <= MEAS;
            end else if (r_scnt != CNT_W'(TIMEOUT)) begin
              // Saturate while waiting; no flag is raised before first lock.
              r_scnt <= w_scnt_inc;
            end
          end
          MEAS: begin
            r_scnt <= w_scnt_inc;
            r_min  <= w_min_n;
            r_max  <= w_max_n;
            if (w_xing) begin
              r_scnt <= '0;
              if (w_close) begin
                r_period  <= CNT_W'(w_sum_n >> AVG_LOG2);
                r_max_o   <= w_max_n;
                r_min_o   <= w_min_n;
                r_pkpk    <= w_max_n - w_min_n;
                r_meas_v  <= 1'b1;
                r_lock    <= 1'b1;
                r_timeout <= 1'b0;
                // Closing sample seeds the next window so windows abut.
                r_sum     <= '0;
                r_pcnt    <= '0;
                r_min     <= w_u;
                r_max     <= w_u;
              end else begin
                r_sum  <= w_sum_n;
                r_pcnt <= w_pcnt_n;
              end
            end else if (w_tmo) begin
              r_lock    <= 1'b0;
              r_timeout <= 1'b1;
              r_scnt    <= '0;
              r_state   <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
